// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : apb_reg_slave
//  Brief    : APB slave with seven R/W registers and a read-only counter of
//             completed error-free transfers, configurable wait states.
//  Revision : 1.0  initial release
// ============================================================================
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_capture;

  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;

  logic [31:0] r_regs [0:6];
  logic [31:0] r_xfer_cnt;

  logic [2:0]  w_idx;
  logic        w_err;
  logic        w_ready;
  logic [31:0] w_rd_mux;
  logic        w_unused_addr_lsbs;

  // Byte-lane bits carry no meaning for word registers.
  assign w_unused_addr_lsbs = ^Paddr[1:0];

  assign w_idx = r_addr[4:2];
  assign w_err = (r_addr[31:5] != BASE_ADDR[31:5]) || (r_write && (w_idx == 3'd7));

  // The SETUP state doubles as the first access-phase cycle once Penable
  // rises, so WAIT_STATES=0 completes on the very first Penable cycle.
  assign w_ready = ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) &&
                   Psel && Penable && (r_cnt == 4'd0);

  assign Pready  = w_ready;
  assign Pslverr = w_ready && w_err;
  assign Prdata  = (w_ready && !r_write && !w_err) ? w_rd_mux : 32'd0;

  // Read mux: REG7 returns the counter value before this cycle's increment.
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_idx)
      3'd0:    w_rd_mux = r_regs[0];
      3'd1:    w_rd_mux = r_regs[1];
      3'd2:    w_rd_mux = r_regs[2];
      3'd3:    w_rd_mux = r_regs[3];
      3'd4:    w_rd_mux = r_regs[4];
      3'd5:    w_rd_mux = r_regs[5];
      3'd6:    w_rd_mux = r_regs[6];
      default: w_rd_mux = r_xfer_cnt;
    endcase
  end

  // Next-state, wait-counter and capture decisions.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Psel && !Penable) begin
          w_next_state = ST_SETUP;
          w_cnt_next   = c_WAIT_INIT;
          w_capture    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (!Psel) begin
          w_next_state = ST_IDLE;
        end else if (!Penable) begin
          w_cnt_next = c_WAIT_INIT;
          w_capture  = 1'b1;
        end else if (r_cnt == 4'd0) begin
          // Completing cycle: Penable is high, so the next setup phase is
          // picked up from IDLE on the following edge without a gap.
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_ACCESS;
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      ST_ACCESS: begin
        if (!Psel || !Penable) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next_state = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Setup-phase capture; bus changes during ACCESS are not seen.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_write <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= Paddr[31:2];
      r_wdata <= Pwdata;
      r_write <= Pwrite;
    end
  end

  // Register bank commit and transfer counter, both only on error-free completion.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      for (int i = 0; i < 7; i++) r_regs[i] <= 32'd0;
      r_xfer_cnt <= 32'd0;
    end else if (w_ready && !w_err) begin
      if (r_write) begin
        for (int i = 0; i < 7; i++) begin
          if (w_idx == 3'(i)) r_regs[i] <= r_wdata;
        end
      end
      r_xfer_cnt <= r_xfer_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire
